// File: rtl/image_window_mem.sv
// image_window_mem: IMG_H x IMG_W pixel store with a 1-cycle random read port and a KxK window streamer.
// Optional IMAGE_WINDOW_ZERO_PAD_EN: windows run over the image framed by (K-1)/2 zero pixels per side.
//
//   state   | meaning
//   IDLE    | waiting for start, writes accepted
//   FETCH   | copying one window tap per cycle into o_data
//   PRESENT | window held on o_data/o_row/o_col until o_ready
module image_window_mem #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 6,
   parameter int IMG_H  = 6,
   parameter int K      = 3,
   parameter int STRIDE = 1,
   localparam int ADDR_W = $clog2(IMG_W*IMG_H),
   localparam int ROW_W  = $clog2(IMG_H+K),
   localparam int COL_W  = $clog2(IMG_W+K)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  wr,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_W-1:0]     wdata,
   output logic                  wr_err,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_W-1:0]     rdata,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  o_valid,
   input  logic                  o_ready,
   output logic [K*K*DATA_W-1:0] o_data,
   output logic [ROW_W-1:0]      o_row,
   output logic [COL_W-1:0]      o_col
);

   localparam int DEPTH = IMG_W*IMG_H;
   localparam int TAPS  = K*K;
   localparam int TAP_W = $clog2(TAPS+1);
`ifdef IMAGE_WINDOW_ZERO_PAD_EN
   localparam int P       = (K-1)/2;
   localparam int FRAME_H = IMG_H + 2*P;
   localparam int FRAME_W = IMG_W + 2*P;
`else
   localparam int FRAME_H = IMG_H;
   localparam int FRAME_W = IMG_W;
`endif
   // top-left corner of the last window that still fits entirely in the frame
   localparam int LAST_ROW = ((FRAME_H-K)/STRIDE)*STRIDE;
   localparam int LAST_COL = ((FRAME_W-K)/STRIDE)*STRIDE;

   typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ROW_W-1:0]  ti;
   logic [COL_W-1:0]  tj;
   logic [TAP_W-1:0]  tap_cnt;
   logic [ROW_W-1:0]  pr;
   logic [COL_W-1:0]  pc;
   logic [DATA_W-1:0] tap_val;
   logic              wr_ok;
   logic              last_tap;
   logic              last_win;
   logic              wrap_col;

   assign wr_ok    = wr && !busy && (32'(waddr) < DEPTH);
   assign last_tap = (tap_cnt == TAP_W'(TAPS-1));
   assign last_win = (32'(o_row) == LAST_ROW) && (32'(o_col) == LAST_COL);
   assign wrap_col = (32'(o_col) + STRIDE > LAST_COL);

   always_comb begin
      pr      = o_row + ti;
      pc      = o_col + tj;
      tap_val = '0;
`ifdef IMAGE_WINDOW_ZERO_PAD_EN
      if ((32'(pr) >= P) && (32'(pr) < IMG_H+P) && (32'(pc) >= P) && (32'(pc) < IMG_W+P))
         tap_val = mem[ADDR_W'((32'(pr)-P)*IMG_W + (32'(pc)-P))];
`else
      tap_val = mem[ADDR_W'(32'(pr)*IMG_W + 32'(pc))];
`endif
   end

   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdata  <= '0;
         wr_err <= 1'b0;
      end else begin
         wr_err <= wr && !wr_ok;
         rdata  <= (32'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         o_valid <= 1'b0;
         o_data  <= '0;
         o_row   <= '0;
         o_col   <= '0;
         ti      <= '0;
         tj      <= '0;
         tap_cnt <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= FETCH;
                  busy    <= 1'b1;
                  o_row   <= '0;
                  o_col   <= '0;
                  ti      <= '0;
                  tj      <= '0;
                  tap_cnt <= '0;
               end
            end
            FETCH: begin
               o_data[DATA_W*32'(tap_cnt) +: DATA_W] <= tap_val;
               tap_cnt <= tap_cnt + 1'b1;
               if (32'(tj) == K-1) begin
                  tj <= '0;
                  ti <= ti + 1'b1;
               end else begin
                  tj <= tj + 1'b1;
               end
               if (last_tap) begin
                  state   <= PRESENT;
                  o_valid <= 1'b1;
                  tap_cnt <= '0;
                  ti      <= '0;
                  tj      <= '0;
               end
            end
            PRESENT: begin
               if (o_ready) begin
                  o_valid <= 1'b0;
                  if (last_win) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= FETCH;
                     if (wrap_col) begin
                        o_col <= '0;
                        o_row <= o_row + ROW_W'(STRIDE);
                     end else begin
                        o_col <= o_col + COL_W'(STRIDE);
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
